// File: rtl/signed_sat_accumulator.sv
// Frame accumulator: sums N_SAMPLES signed samples with per-step saturation and
// presents one result per frame on a valid/ready output held in its own register.
module signed_sat_accumulator #(
    parameter int W_IN      = 4,
    parameter int W_ACC     = 6,
    parameter int N_SAMPLES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    up_valid,
    input  logic signed [W_IN-1:0]  up_data,
    output logic                    up_ready,
    output logic                    down_valid,
    output logic signed [W_ACC-1:0] down_data,
    output logic                    down_sat,
    input  logic                    down_ready
);

    localparam int CW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N_SAMPLES - 1);
    localparam logic signed [W_ACC-1:0] ACC_MAX = {1'b0, {(W_ACC-1){1'b1}}};
    localparam logic signed [W_ACC-1:0] ACC_MIN = {1'b1, {(W_ACC-1){1'b0}}};

    logic signed [W_ACC-1:0] acc_q, acc_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    sat_sticky_q, sat_sticky_d;
    logic                    down_valid_q, down_valid_d;
    logic signed [W_ACC-1:0] down_data_q, down_data_d;
    logic                    down_sat_q, down_sat_d;

    logic signed [W_ACC:0]   s_ext;
    logic signed [W_ACC:0]   t_sum;
    logic signed [W_ACC-1:0] t_clamp;
    logic                    t_sat;
    logic                    is_last;
    logic                    accept;

    always_comb begin
        s_ext = {{(W_ACC+1-W_IN){up_data[W_IN-1]}}, up_data};
        t_sum = {acc_q[W_ACC-1], acc_q} + s_ext;
        t_sat = 1'b0;
        // The extra top bit disagreeing with the result sign bit means overflow.
        if (!t_sum[W_ACC] && t_sum[W_ACC-1]) begin
            t_clamp = ACC_MAX;
            t_sat   = 1'b1;
        end else if (t_sum[W_ACC] && !t_sum[W_ACC-1]) begin
            t_clamp = ACC_MIN;
            t_sat   = 1'b1;
        end else begin
            t_clamp = t_sum[W_ACC-1:0];
        end
    end

    always_comb begin
        is_last  = (cnt_q == CNT_LAST);
        up_ready = !(is_last && down_valid_q && !down_ready);
        accept   = up_valid && up_ready;
    end

    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        sat_sticky_d = sat_sticky_q;
        down_valid_d = down_valid_q;
        down_data_d  = down_data_q;
        down_sat_d   = down_sat_q;

        if (down_valid_q && down_ready) begin
            down_valid_d = 1'b0;
        end

        if (accept) begin
            if (is_last) begin
                down_data_d  = t_clamp;
                down_sat_d   = sat_sticky_q | t_sat;
                down_valid_d = 1'b1;
                acc_d        = '0;
                cnt_d        = '0;
                sat_sticky_d = 1'b0;
            end else begin
                acc_d        = t_clamp;
                cnt_d        = cnt_q + CW'(1);
                sat_sticky_d = sat_sticky_q | t_sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            sat_sticky_q <= 1'b0;
            down_valid_q <= 1'b0;
            down_data_q  <= '0;
            down_sat_q   <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            sat_sticky_q <= sat_sticky_d;
            down_valid_q <= down_valid_d;
            down_data_q  <= down_data_d;
            down_sat_q   <= down_sat_d;
        end
    end

    assign down_valid = down_valid_q;
    assign down_data  = down_data_q;
    assign down_sat   = down_sat_q;

endmodule

// File: tb/tb_signed_sat_accumulator.sv
// Bench for signed_sat_accumulator: directed frames plus a randomized run
// checked against a frame-level saturating-sum reference and result queue.
module tb_signed_sat_accumulator;

    localparam int W_IN  = 4;
    localparam int W_ACC = 6;
    localparam int N     = 8;
    localparam int MAXV  = 2**(W_ACC-1) - 1;
    localparam int MINV  = -(2**(W_ACC-1));

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    up_valid;
    logic signed [W_IN-1:0]  up_data;
    logic                    up_ready;
    logic                    down_valid;
    logic signed [W_ACC-1:0] down_data;
    logic                    down_sat;
    logic                    down_ready;

    int checks = 0;
    int fails  = 0;

    // reference state
    int   frame_buf[$];
    int   exp_data_q[$];
    bit   exp_sat_q[$];
    int   m_cnt;
    bit   m_dv;
    int   frames_done;

    signed_sat_accumulator #(.W_IN(W_IN), .W_ACC(W_ACC), .N_SAMPLES(N)) dut (
        .clk(clk), .rst(rst),
        .up_valid(up_valid), .up_data(up_data), .up_ready(up_ready),
        .down_valid(down_valid), .down_data(down_data), .down_sat(down_sat),
        .down_ready(down_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic frame_result(input int samples[$], output int sum, output bit sat);
        sum = 0;
        sat = 1'b0;
        foreach (samples[i]) begin
            sum = sum + samples[i];
            if (sum > MAXV) begin sum = MAXV; sat = 1'b1; end
            if (sum < MINV) begin sum = MINV; sat = 1'b1; end
        end
    endtask

    task automatic model_clear();
        frame_buf.delete();
        exp_data_q.delete();
        exp_sat_q.delete();
        m_cnt = 0;
        m_dv  = 1'b0;
    endtask

    // One clock cycle: drive, check ready, update reference, check outputs.
    task automatic cycle(input bit v, input int d, input bit r, output bit accepted);
        bit exp_rdy;
        bit hs;
        int fs;
        bit fsat;
        int junk;
        up_valid   = v;
        junk       = v ? d : int'($urandom);
        up_data    = junk[W_IN-1:0];
        down_ready = r;
        #1;
        exp_rdy = !(m_cnt == N-1 && m_dv && !r);
        chk("up_ready", up_ready, exp_rdy);
        accepted = v && exp_rdy;
        hs = m_dv && r;
        if (hs) begin
            if (exp_data_q.size() > 0) begin
                chk("taken_data", down_data, exp_data_q[0]);
                chk("taken_sat", down_sat, exp_sat_q[0]);
                void'(exp_data_q.pop_front());
                void'(exp_sat_q.pop_front());
            end
            m_dv = 1'b0;
        end
        @(posedge clk);
        #1;
        if (accepted) begin
            frame_buf.push_back(d);
            m_cnt++;
            if (m_cnt == N) begin
                frame_result(frame_buf, fs, fsat);
                exp_data_q.push_back(fs);
                exp_sat_q.push_back(fsat);
                frame_buf.delete();
                m_cnt = 0;
                m_dv  = 1'b1;
                frames_done++;
            end
        end
        chk("down_valid", down_valid, m_dv);
        if (m_dv && exp_data_q.size() > 0) begin
            chk("held_data", down_data, exp_data_q[0]);
            chk("held_sat", down_sat, exp_sat_q[0]);
        end
    endtask

    task automatic send(input int d, input bit r);
        bit done;
        int n;
        done = 1'b0;
        n = 0;
        while (!done && n < 50) begin
            cycle(1'b1, d, r, done);
            n++;
        end
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic send_n(input int cnt, input int d, input bit r);
        for (int i = 0; i < cnt; i++) send(d, r);
    endtask

    task automatic expect_out(input string tag, input int d, input bit s);
        chk({tag, "_valid"}, down_valid, 1);
        chk({tag, "_data"}, down_data, d);
        chk({tag, "_sat"}, down_sat, s);
    endtask

    task automatic do_reset();
        bit a;
        rst = 1'b1;
        up_valid = 1'b0;
        down_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_valid", down_valid, 0);
        chk("rst_data", down_data, 0);
        chk("rst_sat", down_sat, 0);
        rst = 1'b0;
        model_clear();
        cycle(1'b0, 0, 1'b1, a);
        chk("post_rst_data", down_data, 0);
        chk("post_rst_sat", down_sat, 0);
    endtask

    initial begin
        bit a;
        int n;
        frames_done = 0;
        rst = 1'b1;
        up_valid = 1'b0;
        up_data = '0;
        down_ready = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // 1: 8 x +3 -> 24, visible right after the 8th accept
        send_n(N, 3, 1'b1);
        expect_out("t1", 24, 1'b0);

        // 2: positive then negative saturation
        send_n(N, 7, 1'b1);
        expect_out("t2a", 31, 1'b1);
        send_n(N, -8, 1'b1);
        expect_out("t2b", -32, 1'b1);

        // 3: clamp mid-frame, recover, sticky cleared next frame
        send_n(5, 7, 1'b1);
        send_n(3, -8, 1'b1);
        expect_out("t3a", 7, 1'b1);
        send_n(N, 0, 1'b1);
        expect_out("t3b", 0, 1'b0);
        cycle(1'b0, 0, 1'b1, a);

        // 4: backpressure across two frames
        send_n(N, 1, 1'b0);
        expect_out("t4a", 8, 1'b0);
        send_n(N-1, 2, 1'b0);
        cycle(1'b1, 2, 1'b0, a);
        chk("t4_stall_ready", up_ready, 0);
        chk("t4_stall_accept", a, 0);
        expect_out("t4_hold", 8, 1'b0);
        send(2, 1'b1);
        expect_out("t4b", 16, 1'b0);
        cycle(1'b0, 0, 1'b1, a);

        // 5: reset mid-frame discards the partial sum
        send_n(5, 4, 1'b1);
        do_reset();
        send_n(N, 1, 1'b1);
        expect_out("t5", 8, 1'b0);
        cycle(1'b0, 0, 1'b1, a);
        chk("t5_single", down_valid, 0);

        // 6: random gaps against the reference
        frames_done = 0;
        n = 0;
        while (frames_done < 1000 && n < 40000) begin
            cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)) - 8,
                  $urandom_range(0, 3) != 0, a);
            n++;
        end
        chk("t6_frames_done", frames_done >= 1000, 1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 0, 1'b1, a);
        chk("t6_queue_empty", exp_data_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
